// File: rtl/servio_rom_reader.sv
// Streams a contiguous, address-wrapping range of an Avalon-MM memory out as one Avalon-ST
// packet. A credit-limited read pipeline keeps the output FIFO from ever overflowing.
module servio_rom_reader #(
    parameter int unsigned DATA_DEPTH = 1024,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned AW = $clog2(DATA_DEPTH),
    localparam int unsigned LW = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic [AW-1:0]         cfg_base,
    input  logic [LW-1:0]         cfg_length,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         avm_m0_address,
    output logic                  avm_m0_read,
    input  logic [DATA_WIDTH-1:0] avm_m0_readdata,
    input  logic                  avm_m0_readdatavalid,
    output logic [DATA_WIDTH-1:0] aso_data,
    output logic                  aso_valid,
    input  logic                  aso_ready,
    output logic                  aso_startofpacket,
    output logic                  aso_endofpacket
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    typedef enum logic [1:0] { IDLE, RUN, FINISH } state_t;

    state_t state, state_next;

    logic [LW-1:0]         length_q, issued_q, popped_q;
    logic [CW-1:0]         outstanding_q, count_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic          start_ok, issue, push, pop, done_next;
    logic [SW-1:0] credit_used;
    logic [CW-1:0] count_next;
    logic [PW-1:0] rd_ptr_next;
    logic [LW-1:0] popped_next;
    logic [AW-1:0] addr_inc;

    // Next-state and per-cycle handshake decisions.
    always_comb begin
        state_next  = state;
        start_ok    = 1'b0;
        issue       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        done_next   = 1'b0;
        credit_used = SW'(outstanding_q) + SW'(count_q);
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_length == '0) begin
                        done_next = 1'b1;
                    end else begin
                        start_ok   = 1'b1;
                        issue      = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                // Every read in flight already owns a FIFO slot.
                issue = (issued_q < length_q) && (credit_used < SW'(FIFO_DEPTH));
                push  = avm_m0_readdatavalid;
                pop   = aso_valid && aso_ready;
                if (pop && aso_endofpacket) begin
                    state_next = FINISH;
                    done_next  = 1'b1;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        count_next  = count_q + CW'(push) - CW'(pop);
        rd_ptr_next = rd_ptr_q + PW'(pop);
        popped_next = start_ok ? '0 : popped_q + LW'(pop);
        addr_inc    = (avm_m0_address == AW'(DATA_DEPTH - 1)) ? '0 : avm_m0_address + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy              <= 1'b0;
            done              <= 1'b0;
            avm_m0_read       <= 1'b0;
            avm_m0_address    <= '0;
            length_q          <= '0;
            issued_q          <= '0;
            popped_q          <= '0;
            outstanding_q     <= '0;
            count_q           <= '0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            aso_valid         <= 1'b0;
            aso_data          <= '0;
            aso_startofpacket <= 1'b0;
            aso_endofpacket   <= 1'b0;
        end else begin
            busy        <= (state_next != IDLE);
            done        <= done_next;
            avm_m0_read <= issue;
            if (start_ok)   avm_m0_address <= cfg_base;
            else if (issue) avm_m0_address <= addr_inc;
            if (start_ok) begin
                length_q      <= cfg_length;
                issued_q      <= LW'(1);
                outstanding_q <= CW'(1);
            end else begin
                issued_q      <= issued_q + LW'(issue);
                outstanding_q <= outstanding_q + CW'(issue) - CW'(push);
            end
            popped_q <= popped_next;
            count_q  <= count_next;
            rd_ptr_q <= rd_ptr_next;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            // Output stage shows the head the FIFO will have next cycle; bypass when it is being written.
            aso_valid         <= (count_next != '0);
            aso_data          <= (push && (wr_ptr_q == rd_ptr_next)) ? avm_m0_readdata
                                                                     : fifo_mem[rd_ptr_next];
            aso_startofpacket <= (count_next != '0) && (popped_next == '0);
            aso_endofpacket   <= (count_next != '0) && (popped_next == length_q - LW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= avm_m0_readdata;
    end

endmodule

// File: tb/tb_servio_rom_reader.sv
// Directed bench for servio_rom_reader: packet-level model checked every cycle,
// plus literal expectations for timing, wrap, back-pressure, zero/one length and reset abort.
module tb_servio_rom_reader;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned DW    = 8;
    localparam int unsigned FD    = 4;
    localparam int unsigned AW    = 10;
    localparam int unsigned LW    = AW + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_start = 1'b0;
    logic [AW-1:0] cfg_base = '0;
    logic [LW-1:0] cfg_length = '0;
    logic          busy, done, avm_m0_read, avm_m0_readdatavalid;
    logic [AW-1:0] avm_m0_address;
    logic [DW-1:0] avm_m0_readdata, aso_data;
    logic          aso_valid, aso_startofpacket, aso_endofpacket;
    logic          aso_ready = 1'b1;

    always #5 clk = ~clk;

    servio_rom_reader #(.DATA_DEPTH(DEPTH), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk                  (clk),
        .reset                (reset),
        .cfg_start            (cfg_start),
        .cfg_base             (cfg_base),
        .cfg_length           (cfg_length),
        .busy                 (busy),
        .done                 (done),
        .avm_m0_address       (avm_m0_address),
        .avm_m0_read          (avm_m0_read),
        .avm_m0_readdata      (avm_m0_readdata),
        .avm_m0_readdatavalid (avm_m0_readdatavalid),
        .aso_data             (aso_data),
        .aso_valid            (aso_valid),
        .aso_ready            (aso_ready),
        .aso_startofpacket    (aso_startofpacket),
        .aso_endofpacket      (aso_endofpacket)
    );

    // Memory holding mem[a] = low byte of a, returned mem_lat cycles after the read.
    int            mem_lat = 1;
    logic          pipe_v [4] = '{default: 1'b0};
    logic [AW-1:0] pipe_a [4] = '{default: '0};
    always @(posedge clk) begin
        pipe_v[0] <= avm_m0_read;
        pipe_a[0] <= avm_m0_address;
        for (int i = 1; i < 4; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
    end
    assign avm_m0_readdatavalid = pipe_v[mem_lat-1];
    assign avm_m0_readdata      = pipe_a[mem_lat-1][DW-1:0];

    int n_chk = 0;
    int n_pass = 0;
    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic int exp_word(input int base, input int i);
        return int'(((base + i) % DEPTH) % (1 << DW));
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Packet-level model state.
    bit          chk_en = 0;
    bit          m_active = 0, m_fin = 0, exp_busy = 0, exp_done = 0, exp_zero = 0;
    bit          done_seen = 0, acc_eop = 0;
    int          m_base = 0, m_len = 0, m_reads = 0, m_acc = 0, start_cyc = 0, done_rel = -1;
    bit          hold_v = 0, hold_s = 0, hold_e = 0;
    logic [DW-1:0] hold_d = '0;
    int          rst_vec = 0;
    int          q_rd_rel[$], q_acc_rel[$], q_addr[$], got[$];

    always @(negedge clk) begin
        if (chk_en) begin
            acc_eop = 0;
            chk(busy == exp_busy, "busy", int'(busy), int'(exp_busy));
            chk(done == exp_done, "done", int'(done), int'(exp_done));
            if (exp_zero) begin
                rst_vec = int'({avm_m0_read, aso_valid, aso_startofpacket, aso_endofpacket, avm_m0_address});
                chk(rst_vec == 0, "reset_outputs", rst_vec, 0);
            end
            if (avm_m0_read) begin
                chk(m_active && (m_reads < m_len), "read_allowed", m_reads, m_len);
                if (m_active) begin
                    chk(int'(avm_m0_address) == int'((m_base + m_reads) % DEPTH), "read_addr",
                        int'(avm_m0_address), int'((m_base + m_reads) % DEPTH));
                    q_addr.push_back(int'(avm_m0_address));
                    q_rd_rel.push_back(cyc - start_cyc);
                    m_reads++;
                    chk((m_reads - m_acc) <= int'(FD), "credit", m_reads - m_acc, int'(FD));
                end
            end
            if (hold_v)
                chk(aso_valid && (aso_data == hold_d) && (aso_startofpacket == hold_s)
                    && (aso_endofpacket == hold_e), "hold_stable", int'(aso_data), int'(hold_d));
            if (aso_valid) begin
                chk(m_active, "valid_in_packet", 0, 1);
                if (m_active && aso_ready) begin
                    chk(m_acc < m_len, "word_count", m_acc, m_len);
                    chk(int'(aso_data) == exp_word(m_base, m_acc), "data",
                        int'(aso_data), exp_word(m_base, m_acc));
                    chk(aso_startofpacket == (m_acc == 0), "sop", int'(aso_startofpacket), int'(m_acc == 0));
                    chk(aso_endofpacket == (m_acc == m_len - 1), "eop",
                        int'(aso_endofpacket), int'(m_acc == m_len - 1));
                    got.push_back(int'(aso_data));
                    q_acc_rel.push_back(cyc - start_cyc);
                    acc_eop = (m_acc == m_len - 1);
                    m_acc++;
                end
            end
            hold_v = aso_valid && !aso_ready;
            hold_d = aso_data;
            hold_s = aso_startofpacket;
            hold_e = aso_endofpacket;
            if (done) begin
                done_seen = 1;
                done_rel  = cyc - start_cyc;
            end
            // Expectations for the next cycle.
            exp_done = 0;
            exp_zero = 0;
            if (reset) begin
                m_active = 0; m_fin = 0; exp_busy = 0; exp_zero = 1; hold_v = 0;
            end else if (m_fin) begin
                m_fin = 0; m_active = 0; exp_busy = 0;
            end else if (!m_active && cfg_start) begin
                start_cyc = cyc;
                m_base = int'(cfg_base); m_len = int'(cfg_length); m_reads = 0; m_acc = 0;
                q_rd_rel.delete(); q_acc_rel.delete(); q_addr.delete(); got.delete();
                if (cfg_length == '0) exp_done = 1;
                else begin m_active = 1; exp_busy = 1; end
            end else if (m_active && acc_eop) begin
                m_fin = 1; exp_done = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pkt(input int base, input int len, input int hold, input bit toggle, input bit poke);
        done_seen  = 0;
        done_rel   = -1;
        cfg_base   = AW'(base);
        cfg_length = LW'(len);
        cfg_start  = 1'b1;
        aso_ready  = (hold > 0) ? 1'b0 : 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 1; k < 400 && !done_seen; k++) begin
            if (poke && k == 5) begin
                cfg_start = 1'b1; cfg_base = '0; cfg_length = LW'(3);
            end else begin
                cfg_start = 1'b0;
            end
            aso_ready = (k < hold) ? 1'b0 : (toggle ? ((k % 2) == 1) : 1'b1);
            tick();
        end
        cfg_start = 1'b0;
        aso_ready = 1'b1;
        chk(done_seen, "done_timeout", int'(done_seen), 1);
        tick();
        tick();
    endtask

    int lit_a [4];
    int lit_d [4];
    int n_hold;

    initial begin
        reset = 1'b1;
        tick();
        chk_en = 1;
        tick();
        chk({busy, done, avm_m0_read, aso_valid} == 4'b0000, "reset_state",
            int'({busy, done, avm_m0_read, aso_valid}), 0);
        reset = 1'b0;
        tick();

        // Basic transfer: 1-cycle memory, ready held high.
        run_pkt('h10, 4, 0, 0, 0);
        chk(q_rd_rel.size() == 4, "t1_nreads", q_rd_rel.size(), 4);
        for (int i = 0; i < q_rd_rel.size() && i < 4; i++)
            chk(q_rd_rel[i] == i + 1, "t1_read_cycle", q_rd_rel[i], i + 1);
        chk(got.size() == 4, "t1_nwords", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) begin
            chk(got[i] == 'h10 + i, "t1_word", got[i], 'h10 + i);
            chk(q_acc_rel[i] == i + 3, "t1_word_cycle", q_acc_rel[i], i + 3);
        end
        chk(done_rel == 7, "t1_done_cycle", done_rel, 7);

        // Address wrap.
        lit_a = '{'h3FE, 'h3FF, 'h000, 'h001};
        lit_d = '{'hFE, 'hFF, 'h00, 'h01};
        run_pkt('h3FE, 4, 0, 0, 0);
        chk(q_addr.size() == 4 && got.size() == 4, "t2_sizes", got.size(), 4);
        for (int i = 0; i < 4 && i < q_addr.size() && i < got.size(); i++) begin
            chk(q_addr[i] == lit_a[i], "t2_addr", q_addr[i], lit_a[i]);
            chk(got[i] == lit_d[i], "t2_word", got[i], lit_d[i]);
        end

        // Sink stalled for 10 cycles: reads limited by FIFO credit, nothing lost.
        run_pkt(0, 8, 10, 0, 0);
        n_hold = 0;
        foreach (q_rd_rel[i]) if (q_rd_rel[i] <= 9) n_hold++;
        chk(n_hold <= int'(FD), "t3_reads_while_stalled", n_hold, int'(FD));
        chk(got.size() == 8, "t3_nwords", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++)
            chk(got[i] == i, "t3_word", got[i], i);

        // Zero length: immediate done, no reads.
        run_pkt('h123, 0, 0, 0, 0);
        chk(done_rel == 1, "t4_done_cycle", done_rel, 1);
        chk(q_rd_rel.size() == 0, "t4_no_reads", q_rd_rel.size(), 0);

        // Single word carries sop and eop.
        run_pkt('h55, 1, 0, 0, 0);
        chk(got.size() == 1, "t5_nwords", got.size(), 1);
        if (got.size() > 0) chk(got[0] == 'h55, "t5_word", got[0], 'h55);
        chk(done_rel == 4, "t5_done_cycle", done_rel, 4);

        // Longer latency, toggling ready, ignored start while busy, wrap.
        mem_lat = 3;
        run_pkt('h3FB, 7, 0, 1, 1);
        chk(got.size() == 7, "t6_nwords", got.size(), 7);
        if (got.size() == 7) chk(got[6] == 'h01, "t6_last_word", got[6], 'h01);
        repeat (4) tick();
        mem_lat = 1;

        // Reset mid-transfer, then a fresh short packet.
        cfg_base = AW'('h20); cfg_length = LW'(8); cfg_start = 1'b1; aso_ready = 1'b1;
        done_seen = 0;
        tick();
        cfg_start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        tick();
        chk({busy, done, avm_m0_read, aso_valid, aso_startofpacket, aso_endofpacket} == 6'b0
            && avm_m0_address == '0, "t7_reset_outputs",
            int'({busy, done, avm_m0_read, aso_valid, aso_startofpacket, aso_endofpacket}), 0);
        reset = 1'b0;
        repeat (3) tick();
        chk(!done_seen, "t7_no_done_on_abort", int'(done_seen), 0);
        run_pkt('h40, 2, 0, 0, 0);
        chk(got.size() == 2, "t7_nwords", got.size(), 2);
        if (got.size() == 2) begin
            chk(got[0] == 'h40, "t7_word0", got[0], 'h40);
            chk(got[1] == 'h41, "t7_word1", got[1], 'h41);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
